// File: rtl/core_seq_pkg.sv
// Sequencer states and constants for the multi-cycle RV32 control FSM.
package core_seq_pkg;

  localparam int unsigned INSN_BYTES = 4;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } seq_state_t;

endpackage

// File: rtl/type_pkg.sv
// Shared scalar types for the RV32 core datapath.
package type_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [XLEN-1:0] data_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC select (jump / taken branch / sequential) with
// alignment check or alignment forcing, depending on TRAP_MISALIGN.
module next_pc_sel
  import type_pkg::*;
  import core_seq_pkg::*;
#(
  parameter bit TRAP_MISALIGN = 1'b1
) (
  input  addr_t pc,
  input  data_t alu_out,
  input  addr_t branch_target,
  input  logic  is_jump,
  input  logic  is_branch,
  input  logic  branch_taken,
  output addr_t next_pc_c,
  output logic  misaligned_c
);

  addr_t raw;

  always_comb begin
    raw          = pc + 32'(INSN_BYTES);
    next_pc_c    = raw;
    misaligned_c = 1'b0;
    if (is_jump) begin
      raw = alu_out & ~32'h0000_0001;
    end else if (is_branch && branch_taken) begin
      raw = branch_target;
    end
    // Either flag a misaligned target for the trap path or silently word-align it.
    if (TRAP_MISALIGN) begin
      next_pc_c    = raw;
      misaligned_c = |raw[1:0];
    end else begin
      next_pc_c    = {raw[31:2], 2'b00};
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32 control FSM: owns PC/IR, runs imem/dmem handshakes,
// pulses the register-file write strobe and counts retired instructions.
module core_sequencer
  import type_pkg::*;
  import core_seq_pkg::*;
#(
  parameter addr_t RESET_PC      = 32'h0000_0000,
  parameter bit    TRAP_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output addr_t       imem_addr,
  input  logic        imem_ack,
  input  data_t       imem_rdata,
  output data_t       ir,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_is_branch,
  input  logic        dec_is_jump,
  input  logic        dec_rd_we,
  input  logic        dec_illegal,
  input  logic        branch_taken,
  input  addr_t       branch_target,
  input  data_t       alu_out,
  output addr_t       pc,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] instret,
  output logic        halted
);

  seq_state_t state, state_next;
  addr_t      next_pc_c;
  logic       misaligned_c;

  next_pc_sel #(
    .TRAP_MISALIGN(TRAP_MISALIGN)
  ) u_next_pc_sel (
    .pc           (pc),
    .alu_out      (alu_out),
    .branch_target(branch_target),
    .is_jump      (dec_is_jump),
    .is_branch    (dec_is_branch),
    .branch_taken (branch_taken),
    .next_pc_c    (next_pc_c),
    .misaligned_c (misaligned_c)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state and handshake strobes; strobes are masked by rst so they drop immediately.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = DECODE;
      end
      DECODE:  state_next = EXECUTE;
      EXECUTE: begin
        if (dec_illegal)                      state_next = TRAP;
        else if (dec_is_load || dec_is_store) state_next = MEMORY;
        else                                  state_next = WRITEBACK;
      end
      MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = dec_is_store;
        if (dmem_ack) state_next = WRITEBACK;
      end
      WRITEBACK: begin
        rf_we      = dec_rd_we & ~dec_is_store;
        state_next = misaligned_c ? TRAP : FETCH;
      end
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
    end
  end

  // Architectural registers; a misaligned target leaves pc/instret untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= NOP_INSN;
      instret <= 32'd0;
      halted  <= 1'b0;
    end else begin
      if (state == FETCH && imem_ack) ir <= imem_rdata;
      if (state == WRITEBACK && !misaligned_c) begin
        pc      <= next_pc_c;
        instret <= instret + 32'd1;
      end
      if (state_next == TRAP) halted <= 1'b1;
    end
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the RV32 core. It owns the PC and the instruction register, and sequences each instruction through fetch, decode, execute, memory and write-back. It runs the instruction/data memory req/ack handshakes and emits the register-file write strobe. It feeds `pc` to the execute stage and selects the next PC from ALU, branch and sequential sources.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_MISALIGN, 1, when 1 a next-PC with bits[1:0]!=0 enters TRAP; when 0 bits[1:0] are forced to 0.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- ir  out  32  instruction register, to decoder
- dec_is_load  in  1  decoder: load
- dec_is_store  in  1  decoder: store
- dec_is_branch  in  1  decoder: conditional branch
- dec_is_jump  in  1  decoder: JAL/JALR (target = alu_out)
- dec_rd_we  in  1  decoder: instruction writes rd
- dec_illegal  in  1  decoder: illegal encoding
- branch_taken  in  1  branch comparator result
- branch_target  in  32  pc+imm for branches
- alu_out  in  32  execute-stage result
- pc  out  32  PC of current instruction (to execute, addr_t)
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write enable, one-cycle pulse
- instret  out  32  retired-instruction counter, wraps
- halted  out  1  sticky trap indication

Behaviour:
- Reset (asynchronous, immediate):
  - State FETCH, pc=RESET_PC, ir=32'h0000_0013 (NOP), instret=0, halted=0.
  - imem_req, dmem_req, dmem_we and rf_we all 0 while rst is high.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- FETCH:
  - imem_req=1 combinationally; imem_addr=pc held stable until ack.
  - On imem_ack: ir<=imem_rdata, go to DECODE.
  - Ack in the first FETCH cycle is legal (zero wait).
- DECODE: one cycle (register-file read). Go to EXECUTE.
- EXECUTE: one cycle. Transitions, in priority order:
  - dec_illegal -> TRAP.
  - dec_is_load or dec_is_store -> MEMORY.
  - Otherwise -> WRITEBACK.
- MEMORY:
  - dmem_req=1 and dmem_we=dec_is_store, held until dmem_ack.
  - On ack, go to WRITEBACK.
- WRITEBACK: one cycle.
  - rf_we = dec_rd_we & ~dec_is_store.
  - pc <= next_pc; instret <= instret+1; go to FETCH.
- next_pc:
  - dec_is_jump: {alu_out[31:1],1'b0}.
  - dec_is_branch & branch_taken: branch_target.
  - Otherwise: pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Misaligned next_pc (bits[1:0]!=0) with TRAP_MISALIGN=1:
  - WRITEBACK still pulses rf_we (link value is written).
  - pc is not updated, instret is not incremented, state goes to TRAP.
- TRAP:
  - halted=1; all requests and rf_we are 0; pc and ir frozen.
  - Only rst exits TRAP.
- Stray acks: imem_ack outside FETCH and dmem_ack outside MEMORY are ignored.
- Latency:
  - Non-memory instruction: 4 cycles with zero-wait fetch, plus fetch wait cycles.
  - Load/store: 5 cycles, plus wait cycles.
- Reset mid-operation: an outstanding imem_req or dmem_req drops in the same cycle as rst rises; no rf_we is issued.
- Decoder inputs are combinational from ir. They must be stable from DECODE through WRITEBACK; the sequencer does not re-register them.

Decomposition:
- New package core_seq_pkg holds: seq_state_t enum (FETCH..TRAP), NOP_INSN constant 32'h0000_0013, INSN_BYTES=4.
- addr_t and data_t are reused from type_pkg.
- One sub-module, next_pc_sel: combinational next-PC select plus misalignment flag. FSM and registers stay in core_sequencer.

Test Plan:
- Reset behaviour -> while rst=1: pc=0, imem_req=0, ir=0x00000013, halted=0. First cycle after release: imem_req=1, imem_addr=0.
- ADDI (dec_rd_we=1) with same-cycle ack:
  - rf_we pulses exactly in cycle 4.
  - pc goes 0->4 and instret 0->1.
  - Next imem_addr=4.
- Fetch ack delayed 3 cycles with rdata changing meanwhile:
  - imem_addr stays constant.
  - ir latches only the value present at the ack cycle.
- Load with dmem_ack 2 cycles after dmem_req:
  - dmem_we=0 throughout; one rf_we pulse; 7 cycles total.
- Store: dmem_we=1 and rf_we=0.
- Branch and jump PC selection:
  - Branch taken, branch_target=0x40 -> pc=0x40.
  - Branch not taken -> pc+4.
  - JALR with alu_out=0x101 -> pc=0x100.
  - Branch target 0x42 -> rf_we=0, pc unchanged, halted=1, no further imem_req.
- dec_illegal in EXECUTE -> TRAP with instret unchanged.
- Reset asserted mid-MEMORY -> dmem_req falls asynchronously, state returns to FETCH, pc=RESET_PC.
